tmds_encoder_mc: RTL and testbench
==================================

// Module: tmds_encoder_mc
// PURPOSE
//  Multi-channel, pipelined DVI/HDMI TMDS encoder: NUM_CH independent 8b/10b lanes with per-lane running disparity.
//  Adds HDMI period modes (video guard band, TERC4 data island, data-island guard band) and a valid pipeline.
//  Sits between the pixel/packet formatter and the 10:1 serializers; one 10-bit symbol per lane per valid beat.
// PARAMETERS
//  NUM_CH      3   number of TMDS lanes; lane c uses role (c % 3): 0=blue, 1=green, 2=red
//  DISP_W      5   running-disparity register width, signed two's complement; minimum 5
// PORTS
//  clk_in      in   1          pixel clock
//  rst_n_in    in   1          asynchronous active-low reset
//  valid_in    in   1          beat qualifier for all *_in below
//  mode_in     in   3          0=CTRL 1=VIDEO 2=VIDEO_GB 3=DATA 4=DATA_GB; 5-7 treated as CTRL
//  data_in     in   NUM_CH*8   video byte, lane c at [8c+7:8c]
//  ctrl_in     in   NUM_CH*2   control bits, lane c at [2c+1:2c] (blue lane carries {vs,hs})
//  aux_in      in   NUM_CH*4   TERC4 nibble, lane c at [4c+3:4c]
//  valid_out   out  1          tmds_out carries a new symbol
//  tmds_out    out  NUM_CH*10  encoded symbols, lane c at [10c+9:10c], bit 0 transmitted first
//  disp_out    out  NUM_CH*DISP_W  per-lane running disparity (only with TMDS_DISP_MON_EN)
// BEHAVIOUR
//  Reset (async, immediate): valid_out=0, tmds_out=0, every lane disparity=0, all pipeline regs cleared.
//  Pipeline: 2 stages, latency exactly 2 cycles valid_in->valid_out; full throughput, one beat per cycle.
//   S1: per lane, transition-minimise to q_m[8:0] (XNOR if N1(d)>4 or N1(d)==4 && d[0]==0, q_m[8]=0; else XOR, q_m[8]=1);
//       register q_m, N1(q_m[7:0]) (4 bits), mode, ctrl, aux, valid.
//   S2: per-mode symbol select + disparity update, registered into tmds_out/valid_out.
//  valid_in=0: bubble; valid_out=0 two cycles later; tmds_out and disparity hold their values.
//  VIDEO (DVI 1.0 DC balance, cnt = lane disparity):
//   cnt==0 or N1==4: out={~q_m8,q_m8,q_m8?q_m[7:0]:~q_m[7:0]}; cnt += q_m8 ? (2N1-8) : (8-2N1)
//   (cnt>0 && N1>4) or (cnt<0 && N1<4): out={1,q_m8,~q_m[7:0]}; cnt += 2*q_m8 + 8 - 2N1
//   else: out={0,q_m8,q_m[7:0]}; cnt += 2N1 - 8 - 2*(~q_m8)
//   Arithmetic sign-extended to DISP_W; |cnt| <= 10 by construction, no saturation logic.
//  CTRL: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (tmds_out[9:0]).
//  VIDEO_GB: role 0,2 -> 0011001101; role 1 -> 1100110010.
//  DATA: TERC4 of aux nibble per HDMI 1.4 TERC4 table, bit-reversed into [9:0] form (0000->0011100101).
//  DATA_GB: role 1,2 -> 1100110010; role 0 -> TERC4 of aux nibble (caller drives {1,1,vs,hs}).
//  Any valid non-VIDEO beat clears that lane's disparity to 0 in S2; VIDEO beats update it.
//  Mode changes between consecutive beats take effect beat-accurately; no extra latency, no dropped beat.
//  Reset asserted mid-stream discards both in-flight beats; first beat after release restarts at cnt=0.
// CONFIGURATION
//  TMDS_DISP_MON_EN defined: disp_out present, driven from the live disparity regs (same cycle as tmds_out).
//  Undefined: disp_out port absent; disparity regs remain internal; encode behaviour identical.
// TESTING
//  1. Stream VIDEO beats, drop rst_n_in between edges -> tmds_out=0, valid_out=0 before next clk edge.
//  2. CTRL, lane0 ctrl=00 then 11, valid_in=1 -> cycles +2,+3: 1101010100, 1010101011; valid_out high.
//  3. VIDEO data=8'h00 twice from reset -> 0100000000 (cnt=-8), then 1111111111 (cnt=+2).
//  4. VIDEO_GB, NUM_CH=3 -> lanes 0/1/2 = 0011001101 / 1100110010 / 0011001101.
//  5. VIDEO 8'h00 (cnt=-8), DATA aux=0000 -> 0011100101, then VIDEO 8'h00 -> 0100000000 (cnt restarted).
//  6. VIDEO 8'h00, bubble (valid_in=0), 8'h00 -> valid_out gap of one cycle, outputs as test 3; with
//     TMDS_DISP_MON_EN disp_out = -8 held across bubble, then +2.

Source files
------------

// File: rtl/tmds_encoder_mc.sv
// Multi-lane pipelined TMDS encoder: 8b/10b video with running disparity, control,
// guard-band and TERC4 periods. Define TMDS_DISP_MON_EN to expose per-lane disparity on disp_out.
module tmds_encoder_mc #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DISP_W = 5
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   valid_in,
   input  logic [2:0]             mode_in,
   input  logic [NUM_CH*8-1:0]    data_in,
   input  logic [NUM_CH*2-1:0]    ctrl_in,
   input  logic [NUM_CH*4-1:0]    aux_in,
   output logic                   valid_out,
   output logic [NUM_CH*10-1:0]   tmds_out
`ifdef TMDS_DISP_MON_EN
   ,
   output logic [NUM_CH*DISP_W-1:0] disp_out
`endif
);

   localparam int unsigned SYM_W    = 10;
   localparam logic [2:0]  MODE_VIDEO    = 3'd1;
   localparam logic [2:0]  MODE_VIDEO_GB = 3'd2;
   localparam logic [2:0]  MODE_DATA     = 3'd3;
   localparam logic [2:0]  MODE_DATA_GB  = 3'd4;
   localparam logic [SYM_W-1:0] GB_A = 10'b0011001101;
   localparam logic [SYM_W-1:0] GB_B = 10'b1100110010;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Transition-minimising stage of the 8b/10b video code
   function automatic logic [8:0] tm_min(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = popcnt8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8]     = ~use_xnor;
      return q;
   endfunction

   // DC-balance stage; returns {new_disparity, symbol}. Arithmetic wraps at DISP_W, the result always fits.
   function automatic logic [DISP_W+9:0] video_enc(input logic [8:0] qm, input logic [3:0] n1,
                                                   input logic [DISP_W-1:0] cnt);
      logic [DISP_W-1:0] n1x2, d8, nc;
      logic [SYM_W-1:0]  sym;
      n1x2 = DISP_W'({n1, 1'b0});
      d8   = DISP_W'(8);
      if ((cnt == '0) || (n1 == 4'd4)) begin
         sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         nc  = qm[8] ? (cnt + n1x2 - d8) : (cnt + d8 - n1x2);
      end else if ((!cnt[DISP_W-1] && (n1 > 4'd4)) || (cnt[DISP_W-1] && (n1 < 4'd4))) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         nc  = cnt + DISP_W'({qm[8], 1'b0}) + d8 - n1x2;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         nc  = cnt + n1x2 - d8 - DISP_W'({~qm[8], 1'b0});
      end
      return {nc, sym};
   endfunction

   function automatic logic [SYM_W-1:0] terc4(input logic [3:0] a);
      logic [SYM_W-1:0] s;
      case (a)
         4'h0: s = 10'b0011100101;  4'h1: s = 10'b1100011001;
         4'h2: s = 10'b0010011101;  4'h3: s = 10'b0100011101;
         4'h4: s = 10'b1000111010;  4'h5: s = 10'b0111100010;
         4'h6: s = 10'b0111000110;  4'h7: s = 10'b0011110010;
         4'h8: s = 10'b0011001101;  4'h9: s = 10'b1001110010;
         4'hA: s = 10'b0011100110;  4'hB: s = 10'b0110001101;
         4'hC: s = 10'b0111000101;  4'hD: s = 10'b1000111001;
         4'hE: s = 10'b1100011010;  default: s = 10'b1100001101;
      endcase
      return s;
   endfunction

   function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
      logic [SYM_W-1:0] s;
      case (c)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   // Stage 1 combinational: q_m and its ones count per lane
   logic [8:0] qm_c [NUM_CH];
   logic [3:0] n1_c [NUM_CH];

   always_comb begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         qm_c[c] = tm_min(data_in[8*c +: 8]);
         n1_c[c] = popcnt8(qm_c[c][7:0]);
      end
   end

   logic [8:0]          qm_s1 [NUM_CH];
   logic [3:0]          n1_s1 [NUM_CH];
   logic [2:0]          mode_s1;
   logic [NUM_CH*2-1:0] ctrl_s1;
   logic [NUM_CH*4-1:0] aux_s1;
   logic                valid_s1;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            qm_s1[c] <= '0;
            n1_s1[c] <= '0;
         end
         mode_s1  <= '0;
         ctrl_s1  <= '0;
         aux_s1   <= '0;
         valid_s1 <= 1'b0;
      end else begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            qm_s1[c] <= qm_c[c];
            n1_s1[c] <= n1_c[c];
         end
         mode_s1  <= mode_in;
         ctrl_s1  <= ctrl_in;
         aux_s1   <= aux_in;
         valid_s1 <= valid_in;
      end
   end

   // Stage 2 combinational: per-mode symbol select; non-video beats reset disparity
   logic [DISP_W-1:0]      disp_q  [NUM_CH];
   logic [DISP_W-1:0]      disp_nx [NUM_CH];
   logic [DISP_W+9:0]      venc    [NUM_CH];
   logic [NUM_CH*10-1:0]   tmds_nx;

   always_comb begin
      tmds_nx = tmds_out;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         disp_nx[c] = disp_q[c];
         venc[c]    = video_enc(qm_s1[c], n1_s1[c], disp_q[c]);
         if (valid_s1) begin
            disp_nx[c] = '0;
            case (mode_s1)
               MODE_VIDEO: begin
                  tmds_nx[10*c +: 10] = venc[c][9:0];
                  disp_nx[c]          = venc[c][DISP_W+9:10];
               end
               MODE_VIDEO_GB: tmds_nx[10*c +: 10] = ((c % 3) == 1) ? GB_B : GB_A;
               MODE_DATA:     tmds_nx[10*c +: 10] = terc4(aux_s1[4*c +: 4]);
               MODE_DATA_GB:  tmds_nx[10*c +: 10] = ((c % 3) == 0) ? terc4(aux_s1[4*c +: 4]) : GB_B;
               default:       tmds_nx[10*c +: 10] = ctrl_sym(ctrl_s1[2*c +: 2]);
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tmds_out  <= '0;
         valid_out <= 1'b0;
         for (int c = 0; c < int'(NUM_CH); c++) disp_q[c] <= '0;
      end else begin
         tmds_out  <= tmds_nx;
         valid_out <= valid_s1;
         for (int c = 0; c < int'(NUM_CH); c++) disp_q[c] <= disp_nx[c];
      end
   end

`ifdef TMDS_DISP_MON_EN
   always_comb begin
      disp_out = '0;
      for (int c = 0; c < int'(NUM_CH); c++) disp_out[DISP_W*c +: DISP_W] = disp_q[c];
   end
`endif

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Scoreboard bench for tmds_encoder_mc: directed beats push hand-computed symbols and
// arrival cycles; a negedge monitor pops and compares whenever valid_out is high.
module tb_tmds_encoder_mc;
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DISP_W = 5;

   localparam logic [2:0] M_CTRL = 3'd0, M_VID = 3'd1, M_VGB = 3'd2, M_DATA = 3'd3, M_DGB = 3'd4;

   logic                   clk_in = 1'b0;
   logic                   rst_n_in;
   logic                   valid_in;
   logic [2:0]             mode_in;
   logic [NUM_CH*8-1:0]    data_in;
   logic [NUM_CH*2-1:0]    ctrl_in;
   logic [NUM_CH*4-1:0]    aux_in;
   logic                   valid_out;
   logic [NUM_CH*10-1:0]   tmds_out;
`ifdef TMDS_DISP_MON_EN
   logic [NUM_CH*DISP_W-1:0] disp_out;
`endif

   tmds_encoder_mc #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .valid_in (valid_in),
      .mode_in  (mode_in),
      .data_in  (data_in),
      .ctrl_in  (ctrl_in),
      .aux_in   (aux_in),
      .valid_out(valid_out),
      .tmds_out (tmds_out)
`ifdef TMDS_DISP_MON_EN
      ,
      .disp_out (disp_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [29:0] sym;
      int          at_cyc;
      logic        dchk;
      logic [14:0] disp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   logic mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   function automatic logic [29:0] rep3(input logic [9:0] s);
      return {s, s, s};
   endfunction

   task automatic drive(input logic v, input logic [2:0] m, input logic [23:0] d,
                        input logic [5:0] c, input logic [11:0] a);
      @(posedge clk_in);
      #1;
      valid_in = v;
      mode_in  = m;
      data_in  = d;
      ctrl_in  = c;
      aux_in   = a;
   endtask

   task automatic beat(input string name, input logic [2:0] m, input logic [23:0] d,
                       input logic [5:0] c, input logic [11:0] a, input logic [29:0] sym,
                       input logic dchk = 1'b0, input logic [14:0] disp = '0);
      exp_t e;
      drive(1'b1, m, d, c, a);
      e.name   = name;
      e.sym    = sym;
      e.at_cyc = cyc + 2;
      e.dchk   = dchk;
      e.disp   = disp;
      sb.push_back(e);
   endtask

   task automatic bubble();
      drive(1'b0, M_CTRL, 24'h0, 6'h0, 12'h0);
   endtask

   // Monitor: every valid symbol must match the oldest expectation and arrive on its cycle
   always @(negedge clk_in) begin
      if (mon_en && rst_n_in && valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid actual=%h required=none", tmds_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_sym"}, 32'(tmds_out), 32'(e.sym));
            chk({e.name, "_cyc"}, 32'(cyc), 32'(e.at_cyc));
`ifdef TMDS_DISP_MON_EN
            if (e.dchk) chk({e.name, "_disp"}, 32'(disp_out), 32'(e.disp));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n_in = 1'b0;
      valid_in = 1'b0;
      mode_in  = M_CTRL;
      data_in  = '0;
      ctrl_in  = '0;
      aux_in   = '0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("reset_tmds", 32'(tmds_out), 32'h0);
      chk("reset_valid", 32'(valid_out), 32'h0);
      rst_n_in = 1'b1;

      // Mid-stream asynchronous reset
      mon_en = 1'b0;
      repeat (4) drive(1'b1, M_VID, 24'h000000, 6'h0, 12'h0);
      @(posedge clk_in);
      #1;
      chk("stream_valid", 32'(valid_out), 32'h1);
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("async_rst_tmds", 32'(tmds_out), 32'h0);
      chk("async_rst_valid", 32'(valid_out), 32'h0);
      valid_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      mon_en   = 1'b1;

      // Video 0x00 twice from reset: disparity 0 -> -8 -> +2
      beat("vid00_a", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b0100000000));
      beat("vid00_b", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b1111111111));

      beat("ctrl00", M_CTRL, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100));
      beat("ctrl11", M_CTRL, 24'h0, 6'b111111, 12'h0, rep3(10'b1010101011));
      beat("ctrl_mix", M_CTRL, 24'h0, 6'b111001, 12'h0,
           {10'b1010101011, 10'b0101010100, 10'b0010101011});
      beat("mode7_ctrl", 3'd7, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100));

      beat("vid_gb", M_VGB, 24'h0, 6'h0, 12'h0, {10'b0011001101, 10'b1100110010, 10'b0011001101});

      // DATA clears disparity between video beats
      beat("vid00_c", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b0100000000));
      beat("data0", M_DATA, 24'h0, 6'h0, 12'h000, rep3(10'b0011100101));
      beat("vid00_d", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b0100000000));

      beat("data_mix", M_DATA, 24'h0, 6'h0, 12'hF81,
           {10'b1100001101, 10'b0011001101, 10'b1100011001});
      beat("data_gb", M_DGB, 24'h0, 6'h0, 12'h55C,
           {10'b1100110010, 10'b1100110010, 10'b0111000101});

      // 0xFF from disparity 0: XNOR path, then both DC-balance branches; then 0x55 (N1==4)
      beat("vidff_a", M_VID, 24'hFFFFFF, 6'h0, 12'h0, rep3(10'b1000000000));
      beat("vidff_b", M_VID, 24'hFFFFFF, 6'h0, 12'h0, rep3(10'b0011111111));
      beat("vidff_c", M_VID, 24'hFFFFFF, 6'h0, 12'h0, rep3(10'b0011111111));
      beat("vidff_d", M_VID, 24'hFFFFFF, 6'h0, 12'h0, rep3(10'b1000000000));
      beat("vid55", M_VID, 24'h555555, 6'h0, 12'h0, rep3(10'b0100110011));

      // Bubble between video beats keeps disparity
      beat("ctrl_clr", M_CTRL, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100));
      beat("bub_a", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b0100000000), 1'b1, {3{5'b11000}});
      bubble();
      beat("bub_b", M_VID, 24'h000000, 6'h0, 12'h0, rep3(10'b1111111111), 1'b1, {3{5'b00010}});
      bubble();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_in);
      @(negedge clk_in);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
